// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the Mips debug read-out logic: dump FSM states,
// source-select encodings and default widths.
package mips_dbg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 11;
  localparam int RF_ADDR_W  = 5;

  localparam logic SRC_RF = 1'b0;
  localparam logic SRC_DM = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/mips_state_dumper.sv
// State read-out engine for the single-cycle Mips core. Walks either the
// register file or the data memory over a word-address range and streams
// each word on a valid/ready interface. All outputs are registered; the
// FSM computes next values combinationally and one register block holds them.
module mips_state_dumper
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state, state_nxt;
  logic              src, src_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [CNT_W-1:0]  remaining, remaining_nxt;
  logic [4:0]        rf_raddr_nxt;
  logic [ADDR_W-1:0] dm_raddr_nxt;
  logic [DATA_W-1:0] dump_data_nxt;
  logic [ADDR_W-1:0] dump_index_nxt;
  logic              dump_last_nxt;
  logic              dump_valid_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] rd_word;

  // Address wraps naturally at 2^ADDR_W; the register file only sees the low 5 bits.
  assign addr_inc = addr + 1'b1;
  assign rd_word  = (src == SRC_DM) ? dm_rdata : rf_rdata;

  // Next-state and next-output logic; every register holds its value unless a state changes it.
  always_comb begin
    state_nxt      = state;
    src_nxt        = src;
    addr_nxt       = addr;
    remaining_nxt  = remaining;
    rf_raddr_nxt   = rf_raddr;
    dm_raddr_nxt   = dm_raddr;
    dump_data_nxt  = dump_data;
    dump_index_nxt = dump_index;
    dump_last_nxt  = dump_last;
    dump_valid_nxt = dump_valid;
    busy_nxt       = busy;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (word_count != '0) begin
            src_nxt       = src_sel;
            addr_nxt      = base_addr;
            remaining_nxt = word_count;
            state_nxt     = READ;
            // The read port is loaded here so the address is presented throughout READ.
            if (src_sel == SRC_RF) begin
              rf_raddr_nxt = base_addr[4:0];
            end else begin
              dm_raddr_nxt = base_addr;
            end
          end else begin
            state_nxt = DONE;
          end
        end
      end

      READ: begin
        state_nxt = CAPTURE;
      end

      CAPTURE: begin
        dump_data_nxt  = rd_word;
        dump_index_nxt = addr;
        dump_last_nxt  = (remaining == CNT_W'(1));
        dump_valid_nxt = 1'b1;
        state_nxt      = SEND;
      end

      SEND: begin
        if (dump_ready) begin
          dump_valid_nxt = 1'b0;
          remaining_nxt  = remaining - 1'b1;
          addr_nxt       = addr_inc;
          if (dump_last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
            if (src == SRC_RF) begin
              rf_raddr_nxt = addr_inc[4:0];
            end else begin
              dm_raddr_nxt = addr_inc;
            end
          end
        end
      end

      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any dump without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= SRC_RF;
      addr       <= '0;
      remaining  <= '0;
      rf_raddr   <= '0;
      dm_raddr   <= '0;
      dump_data  <= '0;
      dump_index <= '0;
      dump_last  <= 1'b0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      src        <= src_nxt;
      addr       <= addr_nxt;
      remaining  <= remaining_nxt;
      rf_raddr   <= rf_raddr_nxt;
      dm_raddr   <= dm_raddr_nxt;
      dump_data  <= dump_data_nxt;
      dump_index <= dump_index_nxt;
      dump_last  <= dump_last_nxt;
      dump_valid <= dump_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mips_state_dumper.sv
// Self-checking bench for mips_state_dumper: synchronous-read memory models,
// an expected-word queue built from the memory contents, and a monitor that
// checks every handshake and every stall cycle.
module tb_mips_state_dumper;
  import mips_dbg_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              src_sel = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [ADDR_W-1:0] dm_raddr;
  logic [DATA_W-1:0] dm_rdata;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic              dump_last;
  logic              busy;
  logic              done;

  int assert_count = 0;
  int fail_count   = 0;

  logic [DATA_W-1:0] rf_mem [0:31];
  logic [DATA_W-1:0] dm_mem [0:1023];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } exp_t;

  exp_t              exp_q [$];
  logic [DATA_W-1:0] cap_data [$];
  logic [ADDR_W-1:0] cap_index [$];
  int                done_count = 0;
  int                words_seen = 0;
  bit                ready_random = 1'b0;
  logic              ready_level = 1'b1;

  mips_state_dumper #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_sel   (src_sel),
    .base_addr (base_addr),
    .word_count(word_count),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dm_raddr  (dm_raddr),
    .dm_rdata  (dm_rdata),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_data (dump_data),
    .dump_index(dump_index),
    .dump_last (dump_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    rf_rdata <= rf_mem[rf_raddr];
    dm_rdata <= dm_mem[dm_raddr];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Consumer ready: fixed level or a coin flip every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      dump_ready = ready_random ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Monitor: every handshake must match the next expected word; stalled words must hold.
  exp_t              mon_e;
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_index;
  logic              prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", 64'(dump_valid), 64'(1'b1));
        checkOutput("hold_data", 64'(dump_data), 64'(prev_data));
        checkOutput("hold_index", 64'(dump_index), 64'(prev_index));
        checkOutput("hold_last", 64'(dump_last), 64'(prev_last));
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL unexpected_word: got index 0x%0h data 0x%0h, expected no word", dump_index, dump_data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("word_data", 64'(dump_data), 64'(mon_e.data));
          checkOutput("word_index", 64'(dump_index), 64'(mon_e.index));
          checkOutput("word_last", 64'(dump_last), 64'(mon_e.last));
        end
        cap_data.push_back(dump_data);
        cap_index.push_back(dump_index);
        words_seen++;
      end
      if (done) done_count++;
      prev_hold  = dump_valid && !dump_ready;
      prev_data  = dump_data;
      prev_index = dump_index;
      prev_last  = dump_last;
    end
  end

  // Pulse start for one cycle, queue the words the request should produce and measure first-word latency.
  task automatic applyStimulus(input logic src, input logic [ADDR_W-1:0] base,
                               input logic [CNT_W-1:0] count, output int latency);
    exp_t e;
    logic [ADDR_W-1:0] idx;
    @(posedge clk);
    #1;
    start      = 1'b1;
    src_sel    = src;
    base_addr  = base;
    word_count = count;
    for (int k = 0; k < int'(count); k++) begin
      idx     = base + ADDR_W'(k);
      e.index = idx;
      e.data  = (src == SRC_DM) ? dm_mem[idx] : rf_mem[idx[4:0]];
      e.last  = (k == int'(count) - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    latency = 1;
    if (count != '0) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dump_valid) break;
        latency++;
      end
    end
  endtask

  // Bounded wait for the done pulse, then check the totals of the dump.
  task automatic waitDone(input string tag, input int words_before, input int done_before, input int expected_words);
    for (int i = 0; i < 600 && done_count == done_before; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 64'(done_count - done_before), 64'(1));
    checkOutput({tag, "_word_total"}, 64'(words_seen - words_before), 64'(expected_words));
    checkOutput({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'(0));
    checkOutput({tag, "_valid_after"}, 64'(dump_valid), 64'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rf_raddr"}, 64'(rf_raddr), 64'(0));
    checkOutput({tag, "_dm_raddr"}, 64'(dm_raddr), 64'(0));
    checkOutput({tag, "_dump_data"}, 64'(dump_data), 64'(0));
    checkOutput({tag, "_dump_index"}, 64'(dump_index), 64'(0));
    checkOutput({tag, "_dump_valid"}, 64'(dump_valid), 64'(0));
    checkOutput({tag, "_dump_last"}, 64'(dump_last), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int wb;
    int db;

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i * 32'h11;
    rf_mem[10] = 32'h00CD_AB00;
    for (int i = 0; i < 1024; i++) dm_mem[i] = 32'h5A00_0000 + i * 32'h0001_0003;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] register-file dump, 32 words");
    cap_data.delete(); cap_index.delete();
    wb = words_seen; db = done_count;
    ready_random = 1'b0; ready_level = 1'b1;
    applyStimulus(SRC_RF, 10'd0, 11'd32, lat);
    checkOutput("rf_latency", 64'(lat), 64'(3));
    waitDone("rf", wb, db, 32);
    checkOutput("rf_reg10", 64'(cap_data[10]), 64'h00CD_AB00);
    checkOutput("rf_index31", 64'(cap_index[31]), 64'd31);

    $display("[TB] data-memory dump with random ready");
    cap_data.delete(); cap_index.delete();
    wb = words_seen; db = done_count;
    ready_random = 1'b1;
    applyStimulus(SRC_DM, 10'd4, 11'd3, lat);
    checkOutput("dm_latency", 64'(lat), 64'(3));
    waitDone("dm", wb, db, 3);
    checkOutput("dm_word5", 64'(cap_data[1]), 64'h5A05_000F);
    ready_random = 1'b0;

    $display("[TB] zero-length request");
    db = done_count; wb = words_seen;
    applyStimulus(SRC_DM, 10'd7, 11'd0, lat);
    @(negedge clk);
    checkOutput("zero_busy_c1", 64'(busy), 64'(1));
    checkOutput("zero_done_c1", 64'(done), 64'(0));
    @(negedge clk);
    checkOutput("zero_busy_c2", 64'(busy), 64'(0));
    checkOutput("zero_done_c2", 64'(done), 64'(1));
    @(negedge clk);
    checkOutput("zero_done_c3", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    checkOutput("zero_done_total", 64'(done_count - db), 64'(1));
    checkOutput("zero_words", 64'(words_seen - wb), 64'(0));

    $display("[TB] data-memory address wrap");
    cap_data.delete(); cap_index.delete();
    wb = words_seen; db = done_count;
    applyStimulus(SRC_DM, 10'h3FE, 11'd4, lat);
    waitDone("wrap", wb, db, 4);
    checkOutput("wrap_idx0", 64'(cap_index[0]), 64'h3FE);
    checkOutput("wrap_idx1", 64'(cap_index[1]), 64'h3FF);
    checkOutput("wrap_idx2", 64'(cap_index[2]), 64'h000);
    checkOutput("wrap_idx3", 64'(cap_index[3]), 64'h001);
    checkOutput("wrap_data1", 64'(cap_data[1]), 64'h5DFF_0BFD);
    checkOutput("wrap_data2", 64'(cap_data[2]), 64'h5A00_0000);

    $display("[TB] start while busy is ignored");
    cap_data.delete(); cap_index.delete();
    wb = words_seen; db = done_count;
    applyStimulus(SRC_RF, 10'd3, 11'd4, lat);
    @(posedge clk);
    #1;
    start = 1'b1; src_sel = SRC_DM; base_addr = 10'd0; word_count = 11'd10;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("busy_start", wb, db, 4);
    repeat (10) @(negedge clk);
    checkOutput("busy_start_no_extra", 64'(words_seen - wb), 64'(4));

    $display("[TB] asynchronous reset mid-transfer");
    db = done_count;
    ready_level = 1'b0;
    applyStimulus(SRC_DM, 10'd8, 11'd3, lat);
    checkOutput("rst_pre_valid", 64'(dump_valid), 64'(1));
    #2 rst = 1'b1;
    #1 checkAllZero("async_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ready_level = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_no_done", 64'(done_count - db), 64'(0));
    cap_data.delete(); cap_index.delete();
    wb = words_seen; db = done_count;
    applyStimulus(SRC_DM, 10'd20, 11'd2, lat);
    checkOutput("post_rst_latency", 64'(lat), 64'(3));
    waitDone("post_rst", wb, db, 2);
    checkOutput("post_rst_idx0", 64'(cap_index[0]), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
